// File: rtl/i2c_req_arbiter_pkg.sv
// rtl/i2c_req_arbiter_pkg.sv - shared constants for the I2C request arbiter
// Contents: FSM state encodings, default hold/timeout lengths and the
// I2C master clock divide ratio that sizes the enable hold window.
package i2c_req_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // The master divides clk by this ratio; one SCL period is twice that.
    localparam int MASTER_DIV = 4;

    localparam int DEF_HOLD_CYCLES    = 2 * MASTER_DIV;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/i2c_req_arbiter_rr_arbiter_n.sv
// rtl/i2c_req_arbiter_rr_arbiter_n.sv - combinational round-robin pick
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  highest-priority requester index
//   grant out N   one-hot pick (all zero when no request)
//   index out IW  encoded pick (zero when no request)
// The caller owns and updates the pointer register.
module rr_arbiter_n #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    always_comb begin
        logic found;
        int   j;
        grant = '0;
        index = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                index    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// rtl/i2c_req_arbiter.sv - round-robin sharing of one single-byte I2C master
// Ports:
//   clk, rst                          clock, async active-high reset
//   req, req_addr, req_wdata, req_rw  per-requester request and payload
//   gnt, done, err, rdata             grant / completion back to requesters
//   m_addr, m_wdata, m_rw, m_enable   registered drive to the I2C master
//   m_ready, m_rdata                  status and read byte from the master
module i2c_req_arbiter
    import i2c_req_arbiter_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [7*N_REQ-1:0]   req_addr,
    input  logic [8*N_REQ-1:0]   req_wdata,
    input  logic [N_REQ-1:0]     req_rw,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic                 err,
    output logic [7:0]           rdata,
    output logic [6:0]           m_addr,
    output logic [7:0]           m_wdata,
    output logic                 m_rw,
    output logic                 m_enable,
    input  logic                 m_ready,
    input  logic [7:0]           m_rdata
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gidx;
    logic [HW-1:0]    hcnt;
    logic [TW-1:0]    tcnt;
    logic [N_REQ-1:0] arb_grant;
    logic [IW-1:0]    arb_index;
    logic             timeout_hit;
    logic             hold_last;
    logic [IW-1:0]    ptr_next;

    rr_arbiter_n #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_arbiter_n (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .index (arb_index)
    );

    assign timeout_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign hold_last   = (hcnt == HW'(HOLD_CYCLES - 1));
    assign ptr_next    = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            gidx     <= '0;
            hcnt     <= '0;
            tcnt     <= '0;
            gnt      <= '0;
            done     <= '0;
            err      <= 1'b0;
            rdata    <= 8'h00;
            m_addr   <= 7'h00;
            m_wdata  <= 8'h00;
            m_rw     <= 1'b0;
            m_enable <= 1'b0;
        end else begin
            // done/err are single-cycle strobes raised only on entry to DONE.
            done <= '0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A master still busy from an aborted transfer keeps
                    // ready low, which holds off the next grant.
                    if ((|req) && m_ready) begin
                        gnt      <= arb_grant;
                        gidx     <= arb_index;
                        m_addr   <= req_addr[7*int'(arb_index) +: 7];
                        m_wdata  <= req_wdata[8*int'(arb_index) +: 8];
                        m_rw     <= req_rw[arb_index];
                        m_enable <= 1'b1;
                        hcnt     <= '0;
                        tcnt     <= '0;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Ready is meaningless here: the master drops it as soon
                    // as it sees enable.
                    tcnt <= tcnt + 1'b1;
                    if (timeout_hit) begin
                        m_enable <= 1'b0;
                        done     <= gnt;
                        err      <= 1'b1;
                        state    <= ST_DONE;
                    end else if (hold_last) begin
                        // Dropping enable before the second ACK phase makes
                        // the master STOP instead of chaining another byte.
                        m_enable <= 1'b0;
                        state    <= ST_WAIT;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (m_ready) begin
                        if (m_rw) begin
                            rdata <= m_rdata;
                        end
                        done  <= gnt;
                        state <= ST_DONE;
                    end else if (timeout_hit) begin
                        done  <= gnt;
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    gnt   <= '0;
                    ptr   <= ptr_next;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb/tb_i2c_req_arbiter.sv - directed self-checking bench for i2c_req_arbiter
module tb_i2c_req_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [7*N-1:0] req_addr = '0;
    logic [8*N-1:0] req_wdata = '0;
    logic [N-1:0]   req_rw = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           err;
    logic [7:0]     rdata;
    logic [6:0]     m_addr;
    logic [7:0]     m_wdata;
    logic           m_rw;
    logic           m_enable;
    logic           m_ready;
    logic [7:0]     m_rdata;

    int passed = 0;
    int total  = 0;

    i2c_req_arbiter #(
        .N_REQ          (N),
        .HOLD_CYCLES    (8),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rw    (req_rw),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rw      (m_rw),
        .m_enable  (m_enable),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-byte master: busy from the first enable cycle,
    // finishes txn_len cycles after enable falls unless hung.
    logic       busy;
    int         cnt;
    logic       hang = 1'b0;
    int         txn_len = 20;
    logic [7:0] slave_data = 8'h00;
    logic [7:0] byte0, byte1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            cnt     <= 0;
            m_rdata <= 8'h00;
        end else if (!busy) begin
            if (m_enable) begin
                busy  <= 1'b1;
                cnt   <= txn_len;
                byte0 <= {m_addr, m_rw};
                byte1 <= m_wdata;
            end
        end else if (!m_enable && !hang) begin
            if (cnt <= 1) begin
                busy    <= 1'b0;
                m_rdata <= m_rw ? slave_data : 8'hFF;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    assign m_ready = !busy && !m_enable;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_gnt(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called on the negedge where gnt was first seen; returns on the negedge
    // showing done, with cyc = negedges elapsed since the grant.
    task automatic wait_done(output logic ok, output int en_cnt, output int cyc);
        ok = 1'b0;
        en_cnt = 0;
        cyc = 0;
        for (int i = 0; i < 500; i++) begin
            if (|done) begin
                ok = 1'b1;
                break;
            end
            if (m_enable) en_cnt++;
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        logic ok;
        logic seen;
        int   en_cnt;
        int   cyc;
        logic [N-1:0] exp_order [4];

        // ---- reset state
        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 4'b0000);
        check("rst_done_err", {done, err}, 5'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_m_bus", {m_enable, m_rw, m_addr, m_wdata}, 17'h0);
        rst = 1'b0;

        // ---- single write from requester 0
        @(negedge clk);
        req_addr[6:0]  = 7'h50;
        req_wdata[7:0] = 8'hA5;
        req_rw[0]      = 1'b0;
        req[0]         = 1'b1;
        wait_gnt(ok);
        check("wr_gnt_seen", ok, 1);
        check("wr_gnt", gnt, 4'b0001);
        check("wr_m_addr", m_addr, 7'h50);
        check("wr_m_wdata", m_wdata, 8'hA5);
        wait_done(ok, en_cnt, cyc);
        check("wr_done_seen", ok, 1);
        check("wr_enable_cycles", en_cnt, 8);
        check("wr_done", done, 4'b0001);
        check("wr_gnt_in_done", gnt, 4'b0001);
        check("wr_err", err, 0);
        check("wr_byte0", byte0, 8'hA0);
        check("wr_byte1", byte1, 8'hA5);
        req[0] = 1'b0;
        @(negedge clk);
        check("wr_done_single", done, 4'b0000);
        check("wr_gnt_release", gnt, 4'b0000);

        // ---- single read from requester 2
        req_addr[20:14] = 7'h3C;
        req_rw[2]       = 1'b1;
        slave_data      = 8'h5E;
        req[2]          = 1'b1;
        wait_gnt(ok);
        check("rd_gnt", gnt, 4'b0100);
        check("rd_m_rw", m_rw, 1);
        wait_done(ok, en_cnt, cyc);
        check("rd_done", done, 4'b0100);
        check("rd_rdata", rdata, 8'h5E);
        check("rd_err", err, 0);
        req[2]     = 1'b0;
        slave_data = 8'h00;
        repeat (5) @(negedge clk);
        check("rd_rdata_held", rdata, 8'h5E);

        // ---- contention from reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_rw = '0;
        req = 4'b1111;
        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b0010;
        exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(ok);
            check("rr4_gnt", gnt, exp_order[k]);
            wait_done(ok, en_cnt, cyc);
            check("rr4_done", done, exp_order[k]);
            req = req & ~exp_order[k];
        end
        req = 4'b1001;
        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b1000;
        for (int k = 0; k < 2; k++) begin
            wait_gnt(ok);
            check("rr2_gnt", gnt, exp_order[k]);
            wait_done(ok, en_cnt, cyc);
            check("rr2_done", done, exp_order[k]);
            req = req & ~exp_order[k];
        end

        // ---- timeout: master hangs once started
        hang   = 1'b1;
        req[1] = 1'b1;
        wait_gnt(ok);
        check("to_gnt", gnt, 4'b0010);
        wait_done(ok, en_cnt, cyc);
        check("to_latency", cyc, 64);
        check("to_done", done, 4'b0010);
        check("to_err", err, 1);
        check("to_enable_low", m_enable, 0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (gnt != '0) seen = 1'b1;
        end
        check("to_no_regrant", seen, 0);
        hang = 1'b0;
        wait_gnt(ok);
        check("to_regrant", gnt, 4'b0010);
        wait_done(ok, en_cnt, cyc);
        check("to_retry_err", err, 0);
        req[1] = 1'b0;

        // ---- reset during WAIT
        @(negedge clk);
        req_addr[27:21] = 7'h11;
        req[3] = 1'b1;
        wait_gnt(ok);
        repeat (12) @(negedge clk);
        check("rw_pre_gnt", gnt, 4'b1000);
        check("rw_pre_enable", m_enable, 0);
        rst = 1'b1;
        #1;
        check("rw_gnt", gnt, 4'b0000);
        check("rw_enable", m_enable, 0);
        check("rw_done", done, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        wait_gnt(ok);
        check("rw_after_gnt", gnt, 4'b1000);
        wait_done(ok, en_cnt, cyc);
        check("rw_after_done", done, 4'b1000);
        check("rw_after_err", err, 0);
        req[3] = 1'b0;

        // ---- NACK: short transaction ending in an early STOP
        txn_len = 6;
        @(negedge clk);
        req[0] = 1'b1;
        wait_gnt(ok);
        check("nack_gnt", gnt, 4'b0001);
        wait_done(ok, en_cnt, cyc);
        check("nack_done", done, 4'b0001);
        check("nack_err", err, 0);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
